// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS-subset controller.
// Holds the FSM state encoding, the fault codes, the alu_op/br_op codes, the
// opcode/funct/rt encodings of the supported subset, the bundle of latched
// control fields and a small helper that tells unconditional branches apart.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF    = 3'd0,
    ST_ID    = 3'd1,
    ST_EX    = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_FAULT = 3'd7
  } state_t;

  // Sequencing class of a decoded instruction.
  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_LOAD   = 3'd1,
    CL_STORE  = 3'd2,
    CL_BRANCH = 3'd3,
    CL_LINK   = 3'd4
  } class_t;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_ILLEGAL = 2'd1;
  localparam logic [1:0] FLT_IMEM    = 2'd2;
  localparam logic [1:0] FLT_DMEM    = 2'd3;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_NOR  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd9;
  localparam logic [4:0] ALU_SRL  = 5'd10;
  localparam logic [4:0] ALU_SRA  = 5'd11;
  localparam logic [4:0] ALU_LUI  = 5'd12;
  localparam logic [4:0] ALU_LINK = 5'd13;

  localparam logic [3:0] BR_NONE   = 4'd0;
  localparam logic [3:0] BR_JR     = 4'd1;
  localparam logic [3:0] BR_J      = 4'd2;
  localparam logic [3:0] BR_JAL    = 4'd3;
  localparam logic [3:0] BR_BAL    = 4'd4;
  localparam logic [3:0] BR_BGEZAL = 4'd5;
  localparam logic [3:0] BR_BLTZ   = 4'd6;
  localparam logic [3:0] BR_BGEZ   = 4'd7;
  localparam logic [3:0] BR_BLTZAL = 4'd8;
  localparam logic [3:0] BR_B      = 4'd9;
  localparam logic [3:0] BR_BEQ    = 4'd10;
  localparam logic [3:0] BR_BNE    = 4'd11;
  localparam logic [3:0] BR_BLEZ   = 4'd12;
  localparam logic [3:0] BR_BGTZ   = 4'd13;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // Control fields latched in ID and held until the next ID.
  typedef struct packed {
    logic [4:0] alu_op;
    logic [3:0] br_op;
    logic       s_imme;  // 1: immediate/normal operand, 0: shamt
    logic       s_a0;    // 1: operand A from rt (shifts)
    logic       s_a;     // 1: operand A from PC (link value)
    logic       s_b;     // 1: operand B from immediate
    logic       s_wra0;  // 1: write address rt (I-type)
    logic       s_wra;   // 0: write address r31 (links)
    logic       s_wrd;   // 1: write data from memory
    logic       s_byte;  // 1: byte access
    logic       s_sign;  // 1: signed operation
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    alu_op: ALU_NOP, br_op: BR_NONE, s_imme: 1'b1, s_a0: 1'b0, s_a: 1'b0,
    s_b: 1'b0, s_wra0: 1'b0, s_wra: 1'b1, s_wrd: 1'b0, s_byte: 1'b0,
    s_sign: 1'b1
  };

  // True for branches/jumps that redirect the PC regardless of br_taken.
  function automatic logic br_uncond(input logic [3:0] op);
    return (op == BR_JR) || (op == BR_J) || (op == BR_JAL) ||
           (op == BR_B) || (op == BR_BAL);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_decode.sv
// mc_decode: purely combinational instruction decoder.
// Ports: opcode/funct/rs/rt (instruction fields) in; ctrl (control field
// bundle), cls (sequencing class) and illegal (unsupported encoding) out.
// b and bal are the rs=0 (and rt=0 for b) aliases of beq and bgezal.
module mc_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit EN_LINK = 1'b1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output ctrl_t      ctrl,
  output class_t     cls,
  output logic       illegal
);

  // Decode table: defaults first, each supported encoding overrides fields.
  always_comb begin
    ctrl    = CTRL_DEFAULT;
    cls     = CL_ALU;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  begin ctrl.alu_op = ALU_SLL; ctrl.s_imme = 1'b0; ctrl.s_a0 = 1'b1; end
          FN_SRL:  begin ctrl.alu_op = ALU_SRL; ctrl.s_imme = 1'b0; ctrl.s_a0 = 1'b1; end
          FN_SRA:  begin ctrl.alu_op = ALU_SRA; ctrl.s_imme = 1'b0; ctrl.s_a0 = 1'b1; end
          FN_JR:   begin cls = CL_BRANCH; ctrl.br_op = BR_JR; end
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_ADDU: begin ctrl.alu_op = ALU_ADD; ctrl.s_sign = 1'b0; end
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_SUBU: begin ctrl.alu_op = ALU_SUB; ctrl.s_sign = 1'b0; end
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_XOR:  ctrl.alu_op = ALU_XOR;
          FN_NOR:  ctrl.alu_op = ALU_NOR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLTU: begin ctrl.alu_op = ALU_SLTU; ctrl.s_sign = 1'b0; end
          default: illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ: begin cls = CL_BRANCH; ctrl.br_op = BR_BLTZ; end
          RT_BGEZ: begin cls = CL_BRANCH; ctrl.br_op = BR_BGEZ; end
          RT_BLTZAL: begin
            cls = CL_LINK; ctrl.br_op = BR_BLTZAL;
            ctrl.alu_op = ALU_LINK; ctrl.s_a = 1'b1; ctrl.s_wra = 1'b0;
          end
          RT_BGEZAL: begin
            cls = CL_LINK; ctrl.br_op = (rs == 5'd0) ? BR_BAL : BR_BGEZAL;
            ctrl.alu_op = ALU_LINK; ctrl.s_a = 1'b1; ctrl.s_wra = 1'b0;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_J:   begin cls = CL_BRANCH; ctrl.br_op = BR_J; end
      OP_JAL: begin
        cls = CL_LINK; ctrl.br_op = BR_JAL;
        ctrl.alu_op = ALU_LINK; ctrl.s_a = 1'b1; ctrl.s_wra = 1'b0;
      end
      OP_BEQ: begin
        cls = CL_BRANCH;
        ctrl.br_op = ((rs == 5'd0) && (rt == 5'd0)) ? BR_B : BR_BEQ;
      end
      OP_BNE:   begin cls = CL_BRANCH; ctrl.br_op = BR_BNE; end
      OP_BLEZ:  begin cls = CL_BRANCH; ctrl.br_op = BR_BLEZ; end
      OP_BGTZ:  begin cls = CL_BRANCH; ctrl.br_op = BR_BGTZ; end
      OP_ADDI:  begin ctrl.alu_op = ALU_ADD;  ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1; end
      OP_ADDIU: begin ctrl.alu_op = ALU_ADD;  ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1; ctrl.s_sign = 1'b0; end
      OP_SLTI:  begin ctrl.alu_op = ALU_SLT;  ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1; end
      OP_SLTIU: begin ctrl.alu_op = ALU_SLTU; ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1; ctrl.s_sign = 1'b0; end
      OP_ANDI:  begin ctrl.alu_op = ALU_AND;  ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1; end
      OP_ORI:   begin ctrl.alu_op = ALU_OR;   ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1; end
      OP_XORI:  begin ctrl.alu_op = ALU_XOR;  ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1; end
      OP_LUI:   begin ctrl.alu_op = ALU_LUI;  ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1; end
      OP_LB: begin
        cls = CL_LOAD; ctrl.alu_op = ALU_ADD; ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1;
        ctrl.s_wrd = 1'b1; ctrl.s_byte = 1'b1;
      end
      OP_LW: begin
        cls = CL_LOAD; ctrl.alu_op = ALU_ADD; ctrl.s_b = 1'b1; ctrl.s_wra0 = 1'b1;
        ctrl.s_wrd = 1'b1;
      end
      OP_SB: begin
        cls = CL_STORE; ctrl.alu_op = ALU_ADD; ctrl.s_b = 1'b1; ctrl.s_byte = 1'b1;
      end
      OP_SW: begin
        cls = CL_STORE; ctrl.alu_op = ALU_ADD; ctrl.s_b = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Link branches need the r31 write path; without it they are unsupported.
    if (!EN_LINK && (cls == CL_LINK)) begin
      illegal = 1'b1;
    end else begin
      illegal = illegal;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: sequencing FSM of a multi-cycle MIPS-subset core.
// Ports: clk, rst (sync, active high); run, IR fields (opcode/funct/rs/rt),
// imem_ready/dmem_ready handshakes, br_taken in; per-state pulse enables
// (imem_req, ir_we, pc_we, pc_br_we, dmem_re, dmem_we, reg_we), latched
// control fields (alu_op, br_op, s_*), state, fault code and retired count out.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32,
  parameter bit          EN_LINK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_br_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             reg_we,
  output logic [4:0]       alu_op,
  output logic [3:0]       br_op,
  output logic             s_imme,
  output logic             s_a0,
  output logic             s_a,
  output logic             s_b,
  output logic             s_wra0,
  output logic             s_wra,
  output logic             s_wrd,
  output logic             s_byte,
  output logic             s_sign,
  output logic [2:0]       state,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state_r, state_nx;
  logic [1:0]        fault_r, fault_nx;
  logic [WAIT_W-1:0] wait_r, wait_nx, wait_inc;
  logic [CNT_W-1:0]  retired_r;
  ctrl_t             ctrl_r, dec_ctrl;
  class_t            cls_r, dec_cls;
  logic              dec_illegal;
  logic              retire, latch, timeout_hit;

  mc_decode #(.EN_LINK(EN_LINK)) u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .rs      (rs),
    .rt      (rt),
    .ctrl    (dec_ctrl),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // Saturating increment; the comparison is against the count including the
  // current not-ready cycle, so a ready on the TIMEOUT-th cycle still wins.
  assign wait_inc    = (&wait_r) ? wait_r : wait_r + WAIT_W'(1);
  assign timeout_hit = (TIMEOUT != 32'd0) && (wait_inc == WAIT_W'(TIMEOUT));

  // Next-state, wait counter and per-state pulse decode.
  always_comb begin
    state_nx = state_r;
    fault_nx = fault_r;
    wait_nx  = '0;
    retire   = 1'b0;
    latch    = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_br_we = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    case (state_r)
      ST_IF: begin
        imem_req = run;
        if (!run) begin
          wait_nx = wait_r;
        end else if (imem_ready) begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = ST_ID;
        end else if (timeout_hit) begin
          state_nx = ST_FAULT;
          fault_nx = FLT_IMEM;
        end else begin
          wait_nx = wait_inc;
        end
      end
      ST_ID: begin
        if (dec_illegal) begin
          state_nx = ST_FAULT;
          fault_nx = FLT_ILLEGAL;
        end else begin
          latch    = 1'b1;
          state_nx = ST_EX;
        end
      end
      ST_EX: begin
        case (cls_r)
          CL_ALU:   state_nx = ST_WB;
          CL_LOAD:  state_nx = ST_MEM;
          CL_STORE: state_nx = ST_MEM;
          CL_LINK: begin
            pc_br_we = br_uncond(ctrl_r.br_op) | br_taken;
            state_nx = ST_WB;
          end
          CL_BRANCH: begin
            pc_br_we = br_uncond(ctrl_r.br_op) | br_taken;
            retire   = 1'b1;
            state_nx = ST_IF;
          end
          default: state_nx = ST_IF;
        endcase
      end
      ST_MEM: begin
        dmem_re = (cls_r == CL_LOAD);
        dmem_we = (cls_r == CL_STORE);
        if (dmem_ready) begin
          if (cls_r == CL_LOAD) begin
            state_nx = ST_WB;
          end else begin
            retire   = 1'b1;
            state_nx = ST_IF;
          end
        end else if (timeout_hit) begin
          state_nx = ST_FAULT;
          fault_nx = FLT_DMEM;
        end else begin
          wait_nx = wait_inc;
        end
      end
      ST_WB: begin
        reg_we   = 1'b1;
        retire   = 1'b1;
        state_nx = ST_IF;
      end
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_IF;
    endcase
  end

  // State, fault, wait counter, retired counter and latched control fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IF;
      fault_r   <= FLT_NONE;
      wait_r    <= '0;
      retired_r <= '0;
      ctrl_r    <= '0;
      cls_r     <= CL_ALU;
    end else begin
      state_r <= state_nx;
      fault_r <= fault_nx;
      wait_r  <= wait_nx;
      if (retire) begin
        retired_r <= retired_r + CNT_W'(1);
      end
      if (latch) begin
        ctrl_r <= dec_ctrl;
        cls_r  <= dec_cls;
      end
    end
  end

  assign state   = state_r;
  assign fault   = fault_r;
  assign retired = retired_r;
  assign alu_op  = ctrl_r.alu_op;
  assign br_op   = ctrl_r.br_op;
  assign s_imme  = ctrl_r.s_imme;
  assign s_a0    = ctrl_r.s_a0;
  assign s_a     = ctrl_r.s_a;
  assign s_b     = ctrl_r.s_b;
  assign s_wra0  = ctrl_r.s_wra0;
  assign s_wra   = ctrl_r.s_wra;
  assign s_wrd   = ctrl_r.s_wrd;
  assign s_byte  = ctrl_r.s_byte;
  assign s_sign  = ctrl_r.s_sign;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm. Stimulus pushes the expected
// per-cycle trace (state + pulse vector, plus control fields in EX); a monitor
// pops an entry whenever the DUT shows a pulse or changes state.
// A second instance (EN_LINK=0, CNT_W=3) covers link-illegal and wrap.
module tb_multicycle_ctrl_fsm;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_FLT = 3'd7;
  // {imem_req, ir_we, pc_we, pc_br_we, dmem_re, dmem_we, reg_we}
  localparam logic [6:0] P_NONE = 7'b0000000, P_IMREQ = 7'b1000000,
                         P_FETCH = 7'b1110000, P_BR = 7'b0001000,
                         P_RD = 7'b0000100, P_WR = 7'b0000010, P_WB = 7'b0000001;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_LINK = 4,
                 K_ILL = 5, K_ITO = 6, K_DTO = 7;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] pl;
    logic       chk;
    logic [4:0] alu;
    logic [3:0] br;
    logic [8:0] sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, run, imem_ready, dmem_ready, br_taken;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;

  logic imem_req, ir_we, pc_we, pc_br_we, dmem_re, dmem_we, reg_we;
  logic [4:0] alu_op;
  logic [3:0] br_op;
  logic s_imme, s_a0, s_a, s_b, s_wra0, s_wra, s_wrd, s_byte, s_sign;
  logic [2:0] state;
  logic [1:0] fault;
  logic [31:0] retired;

  logic alt_imem_req, alt_ir_we, alt_pc_we, alt_pc_br_we, alt_dmem_re, alt_dmem_we, alt_reg_we;
  logic [4:0] alt_alu_op;
  logic [3:0] alt_br_op;
  logic alt_s_imme, alt_s_a0, alt_s_a, alt_s_b, alt_s_wra0, alt_s_wra, alt_s_wrd, alt_s_byte, alt_s_sign;
  logic [2:0] alt_state;
  logic [1:0] alt_fault;
  logic [2:0] alt_retired;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.TIMEOUT(16), .CNT_W(32), .EN_LINK(1'b1)) u_dut (
    .clk(clk), .rst(rst_a), .run(run), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .br_taken(br_taken),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_br_we(pc_br_we),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .reg_we(reg_we), .alu_op(alu_op), .br_op(br_op),
    .s_imme(s_imme), .s_a0(s_a0), .s_a(s_a), .s_b(s_b), .s_wra0(s_wra0), .s_wra(s_wra),
    .s_wrd(s_wrd), .s_byte(s_byte), .s_sign(s_sign), .state(state), .fault(fault),
    .retired(retired)
  );

  multicycle_ctrl_fsm #(.TIMEOUT(16), .CNT_W(3), .EN_LINK(1'b0)) u_alt (
    .clk(clk), .rst(rst_b), .run(run), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .br_taken(br_taken),
    .imem_req(alt_imem_req), .ir_we(alt_ir_we), .pc_we(alt_pc_we), .pc_br_we(alt_pc_br_we),
    .dmem_re(alt_dmem_re), .dmem_we(alt_dmem_we), .reg_we(alt_reg_we), .alu_op(alt_alu_op),
    .br_op(alt_br_op), .s_imme(alt_s_imme), .s_a0(alt_s_a0), .s_a(alt_s_a), .s_b(alt_s_b),
    .s_wra0(alt_s_wra0), .s_wra(alt_s_wra), .s_wrd(alt_s_wrd), .s_byte(alt_s_byte),
    .s_sign(alt_s_sign), .state(alt_state), .fault(alt_fault), .retired(alt_retired)
  );

  wire [6:0] pulses = {imem_req, ir_we, pc_we, pc_br_we, dmem_re, dmem_we, reg_we};
  wire [8:0] sel = {s_imme, s_a0, s_a, s_b, s_wra0, s_wra, s_wrd, s_byte, s_sign};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [6:0] pl);
    q.push_back('{st: st, pl: pl, chk: 1'b0, alu: 5'd0, br: 4'd0, sel: 9'd0});
  endtask

  task automatic push_c(input logic [2:0] st, input logic [6:0] pl,
                        input logic [4:0] alu, input logic [3:0] br, input logic [8:0] sl);
    q.push_back('{st: st, pl: pl, chk: 1'b1, alu: alu, br: br, sel: sl});
  endtask

  // One instruction: iw not-ready fetch cycles, dw not-ready MEM cycles.
  // brw is the hand-computed pc_br_we value in EX; trk=0 skips the scoreboard.
  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rsv,
                      input logic [4:0] rtv, input int kind, input int iw, input int dw,
                      input logic taken, input logic brw, input logic [4:0] alu,
                      input logic [3:0] br, input logic [8:0] sl, input bit trk);
    if (trk) begin
      for (int k = 0; k < iw; k++) push(S_IF, P_IMREQ);
      if (kind == K_ITO) begin
        push(S_FLT, P_NONE);
      end else begin
        push(S_IF, P_FETCH);
        push(S_ID, P_NONE);
        case (kind)
          K_ILL: push(S_FLT, P_NONE);
          K_ALU: begin push_c(S_EX, P_NONE, alu, br, sl); push(S_WB, P_WB); push(S_IF, P_NONE); end
          K_LOAD: begin
            push_c(S_EX, P_NONE, alu, br, sl);
            for (int k = 0; k <= dw; k++) push(S_MEM, P_RD);
            push(S_WB, P_WB); push(S_IF, P_NONE);
          end
          K_STORE: begin
            push_c(S_EX, P_NONE, alu, br, sl);
            for (int k = 0; k <= dw; k++) push(S_MEM, P_WR);
            push(S_IF, P_NONE);
          end
          K_DTO: begin
            push_c(S_EX, P_NONE, alu, br, sl);
            for (int k = 0; k < 16; k++) push(S_MEM, P_RD);
            push(S_FLT, P_NONE);
          end
          K_BR: begin push_c(S_EX, brw ? P_BR : P_NONE, alu, br, sl); push(S_IF, P_NONE); end
          default: begin
            push_c(S_EX, brw ? P_BR : P_NONE, alu, br, sl); push(S_WB, P_WB); push(S_IF, P_NONE);
          end
        endcase
      end
      if (kind <= K_LINK) exp_ret++;
    end
    opcode = op; funct = fn; rs = rsv; rt = rtv; br_taken = taken;
    for (int c = 0; c < iw + dw + 8; c++) begin
      run        = (c <= iw);
      imem_ready = (c == iw) && (kind != K_ITO);
      dmem_ready = (c >= iw + 3 + dw) && (kind != K_DTO);
      @(posedge clk); #1;
    end
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    if (trk) chk("retired", retired, exp_ret);
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("rst_state", state, S_IF);
    chk("rst_fault", fault, 2'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_ctrl", {alu_op, br_op, sel}, 18'd0);
    rst_a = 1'b0;
    exp_ret = 0;
  endtask

  // Monitor: pop and compare on every pulse or state change of the main DUT.
  initial begin
    logic [2:0] prev;
    exp_t e;
    prev = S_IF;
    forever begin
      @(negedge clk);
      if (!rst_a && ((pulses != P_NONE) || (state != prev))) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event state=%0d pulses=%b", state, pulses);
        end else begin
          e = q.pop_front();
          if ((state != e.st) || (pulses != e.pl) ||
              (e.chk && ((alu_op != e.alu) || (br_op != e.br) || (sel != e.sel)))) begin
            miscompares++;
            $display("FAIL trace actual state=%0d pulses=%b alu=%0d br=%0d sel=%b required state=%0d pulses=%b alu=%0d br=%0d sel=%b (ctrl checked=%0d)",
                     state, pulses, alu_op, br_op, sel, e.st, e.pl, e.alu, e.br, e.sel, e.chk);
          end
        end
      end
      prev = state;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    br_taken = 1'b0; opcode = 6'd0; funct = 6'd0; rs = 5'd0; rt = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    @(posedge clk); #1;

    // op, fn, rs, rt, kind, iw, dw, taken, brw, alu, br, sel, track
    exec(6'h00, 6'h21, 5'd1, 5'd2, K_ALU,   0, 0, 1'b0, 1'b0, 5'd1,  4'd0,  9'b100001000, 1'b1); // addu
    exec(6'h23, 6'h00, 5'd1, 5'd2, K_LOAD,  0, 3, 1'b0, 1'b0, 5'd1,  4'd0,  9'b100111101, 1'b1); // lw
    exec(6'h04, 6'h00, 5'd3, 5'd4, K_BR,    0, 0, 1'b1, 1'b1, 5'd0,  4'd10, 9'b100001001, 1'b1); // beq taken
    exec(6'h04, 6'h00, 5'd3, 5'd4, K_BR,    0, 0, 1'b0, 1'b0, 5'd0,  4'd10, 9'b100001001, 1'b1); // beq not taken
    exec(6'h01, 6'h00, 5'd5, 5'h11, K_LINK, 0, 0, 1'b0, 1'b0, 5'd13, 4'd5,  9'b101000001, 1'b1); // bgezal
    exec(6'h01, 6'h00, 5'd0, 5'h11, K_LINK, 0, 0, 1'b0, 1'b1, 5'd13, 4'd4,  9'b101000001, 1'b1); // bal
    exec(6'h28, 6'h00, 5'd1, 5'd2, K_STORE, 0, 1, 1'b0, 1'b0, 5'd1,  4'd0,  9'b100101011, 1'b1); // sb
    exec(6'h00, 6'h00, 5'd0, 5'd2, K_ALU,   0, 0, 1'b0, 1'b0, 5'd9,  4'd0,  9'b010001001, 1'b1); // sll
    exec(6'h0f, 6'h00, 5'd0, 5'd2, K_ALU,   0, 0, 1'b0, 1'b0, 5'd12, 4'd0,  9'b100111001, 1'b1); // lui
    exec(6'h0b, 6'h00, 5'd1, 5'd2, K_ALU,   0, 0, 1'b0, 1'b0, 5'd8,  4'd0,  9'b100111000, 1'b1); // sltiu
    exec(6'h00, 6'h08, 5'd7, 5'd0, K_BR,    0, 0, 1'b0, 1'b1, 5'd0,  4'd1,  9'b100001001, 1'b1); // jr
    exec(6'h03, 6'h00, 5'd0, 5'd0, K_LINK,  0, 0, 1'b0, 1'b1, 5'd13, 4'd3,  9'b101000001, 1'b1); // jal
    exec(6'h08, 6'h00, 5'd1, 5'd2, K_ALU,  15, 0, 1'b0, 1'b0, 5'd1,  4'd0,  9'b100111001, 1'b1); // addi, ready on 16th cycle

    // run=0: no request, no timeout
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("run0_imem_req", imem_req, 1'b0);
    end
    @(posedge clk); #1;
    chk("run0_state", state, S_IF);
    chk("run0_fault", fault, 2'd0);

    exec(6'h3f, 6'h00, 5'd0, 5'd0, K_ILL, 0, 0, 1'b0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b1);
    chk("illegal_fault", fault, 2'd1);
    chk("illegal_state", state, S_FLT);
    do_reset();

    exec(6'h00, 6'h21, 5'd1, 5'd2, K_ITO, 16, 0, 1'b0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b1);
    chk("imem_to_fault", fault, 2'd2);
    chk("imem_to_state", state, S_FLT);
    chk("imem_to_pulses", pulses, P_NONE);
    do_reset();

    exec(6'h23, 6'h00, 5'd1, 5'd2, K_DTO, 0, 16, 1'b0, 1'b0, 5'd1, 4'd0, 9'b100111101, 1'b1);
    chk("dmem_to_fault", fault, 2'd3);
    chk("dmem_to_state", state, S_FLT);
    do_reset();

    exec(6'h00, 6'h23, 5'd1, 5'd2, K_ALU, 0, 0, 1'b0, 1'b0, 5'd2, 4'd0, 9'b100001000, 1'b1); // subu
    @(posedge clk); #1;
    chk("queue_drained", q.size(), 0);

    // Second instance: 3-bit counter wrap and EN_LINK=0.
    rst_a = 1'b1;
    rst_b = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      exec(6'h00, 6'h21, 5'd1, 5'd2, K_ALU, 0, 0, 1'b0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
      if (n == 7) chk("alt_retired_max", alt_retired, 3'd7);
    end
    chk("alt_retired_wrap", alt_retired, 3'd0);
    exec(6'h01, 6'h00, 5'd5, 5'h11, K_ILL, 0, 0, 1'b0, 1'b0, 5'd0, 4'd0, 9'd0, 1'b0);
    chk("alt_link_fault", alt_fault, 2'd1);
    chk("alt_link_state", alt_state, S_FLT);
    chk("alt_link_retired", alt_retired, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle MIPS-subset controller: a decode table plus a sequencing FSM that issues per-state enables to the multi-cycle datapath (PC, IR, register file, ALU, data memory).
- Handles instruction and data memory with variable latency through ready handshakes, with a parametrised timeout on each wait.
- Detects illegal instructions and parks in a sticky FAULT state.
- Counts retired instructions.
- Sits between the IR/branch comparator and the datapath muxes/write enables.

Parameters:
- TIMEOUT, 16, maximum wait cycles in IF or MEM before a bus fault; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.
- EN_LINK, 1, when 0 the link-type branches (jal, bal, bgezal, bltzal) decode as illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- run  in  1  allow a new fetch at an instruction boundary
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- rs  in  5  IR[25:21]
- rt  in  5  IR[20:16]
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- br_taken  in  1  branch condition true (sampled in EX)
- imem_req  out  1  fetch request
- ir_we  out  1  load IR
- pc_we  out  1  load PC+4
- pc_br_we  out  1  load the branch/jump target
- dmem_re  out  1  data read request
- dmem_we  out  1  data write request
- reg_we  out  1  register-file write
- alu_op  out  5  ALU operation: 0 nop, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor, 7 slt, 8 sltu, 9 sll, 10 srl, 11 sra, 12 lui, 13 link
- br_op  out  4  branch operation: 0 none, 1 jr, 2 j, 3 jal, 4 bal, 5 bgezal, 6 bltz, 7 bgez, 8 bltzal, 9 b, 10 beq, 11 bne, 12 blez, 13 bgtz
- s_imme, s_a0, s_a, s_b, s_wra0, s_wra, s_wrd, s_byte, s_sign  out  1 each  datapath mux selects, latched in ID
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, FAULT=7
- fault  out  2  0 none, 1 illegal instruction, 2 imem timeout, 3 dmem timeout
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: state=IF, fault=0, retired=0, wait counter=0, all latched selects/alu_op/br_op=0. rst overrides every other input in the same cycle; reset mid-wait abandons the access.
- Pulse outputs (imem_req, ir_we, pc_we, pc_br_we, dmem_re, dmem_we, reg_we) are decoded from state and are 0 in every state not listed below.
- IF: imem_req = run. On run and imem_ready: ir_we=1, pc_we=1, go to ID. With run=0 the FSM holds in IF and the wait counter does not count.
- ID: decode opcode/funct/rs/rt and latch all control fields. An unsupported encoding goes to FAULT with fault=1 (EN_LINK=0 makes the link branches unsupported). Otherwise go to EX. Always 1 cycle.
- EX, ALU-class (R-type ALU, addi/addiu/andi/ori/xori/lui/slti/sltiu): go to WB.
- EX, loads and stores (lw, lb, sw, sb): go to MEM.
- EX, branch/jump: pc_br_we = unconditional (j, jal, jr, b, bal) | br_taken.
  - Link forms (jal, bal; bgezal, bltzal whether taken or not) go to WB.
  - All other branches/jumps retire here and go to IF.
- MEM: dmem_re held for loads, dmem_we held for stores, until dmem_ready. Then a load goes to WB; a store retires and goes to IF.
- WB: reg_we=1 for one cycle, retire, go to IF.
- Minimum cycles per instruction: ALU 4, load 5, store 4, branch/jump 3, link 4.
- Wait counter counts consecutive not-ready cycles in IF (with run=1) or MEM, and clears on ready or state change. When it reaches TIMEOUT with the memory still not ready, go to FAULT (fault=2 from IF, 3 from MEM). Ready arriving on the TIMEOUT-th cycle wins over the fault.
- FAULT: all pulse outputs 0; sticky until rst.
- retired increments by 1 on each retire cycle and wraps modulo 2^CNT_W.
- Decode rules:
  - Signed ops: add, sub, addi, slt, slti, and the remaining non-unsigned ops all set s_sign=1. Unsigned ops (addu, subu, sltu, addiu, sltiu) set s_sign=0.
  - Shift amount: s_imme=0 for sll/srl/sra (shamt), 1 otherwise.
  - Write address: s_wra0=1 selects rt for I-type results; s_wra=0 selects r31 for links.
  - s_wrd=1 for loads (write data from memory).
  - s_byte=1 for lb/sb.
  - lui: alu_op=12, s_b=1.

Decomposition:
- Package mc_ctrl_pkg holds: state encodings, fault codes, alu_op and br_op constants, opcode/funct constants.
- One sub-module, mc_decode: purely combinational (opcode, funct, rs, rt) → {class, illegal, control fields}. The FSM, wait counter and retired counter stay in the top module.

Test Plan:
- addu (op 0, funct 0x21), imem_ready=1 → ir_we/pc_we at cycle 0, reg_we at cycle 3, alu_op=1, s_sign=0, retired 0→1.
- lw with dmem_ready low for 3 cycles → dmem_re high for 4 cycles, reg_we 1 cycle later, s_wrd=1, total 8 cycles.
- beq with br_taken=1, then beq with br_taken=0 → pc_br_we=1 in EX for the first only; each takes 3 cycles.
- bgezal (op 1, rt=0x11) with EN_LINK=1 → br_op=5, alu_op=13, reg_we=1 in WB, s_wra=0. With EN_LINK=0 → fault=1, FAULT entered after ID.
- imem_ready held 0, TIMEOUT=16 → FAULT with fault=2 after 16 wait cycles, pulse outputs 0. rst → state=IF, fault=0, retired=0.
- run=0 at IF for 5 cycles → imem_req=0, no timeout. retired at all-ones plus one retire → wraps to 0.
